jump_kinematics: RTL and testbench

Single-clock responder for the jump handshake driven by `wechat_jump_fsm`. The FSM raises an enable and presents an initial vertical velocity. This block then integrates a parabolic trajectory on each step-enable tick and reports height and horizontal distance. It asserts done on landing. It replaces a derived-clock trajectory generator: all state runs on `clk_machine`, and the step rate comes from a one-cycle `i_tick` strobe derived from `clkdiv`.

---
 rtl/jump_kinematics.sv | 89 ++++++++
 tb/tb_jump_kinematics.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/jump_kinematics.sv
// Parabolic jump trajectory integrator: steps height/distance on each i_tick
// strobe while in flight and flags landing to the controlling FSM.
module jump_kinematics #(
  parameter int GRAV   = 1,
  parameter int DX     = 1,
  parameter int HSHIFT = 5
) (
  input  logic        clk_machine,
  input  logic        rst_machine,
  input  logic        i_tick,
  input  logic        i_en,
  input  logic [10:0] i_v_init,
  output logic [8:0]  o_height,
  output logic [10:0] o_dist,
  output logic        o_done,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

  state_t             state_reg, state_next;
  logic signed [12:0] vy_reg, vy_next;
  logic signed [23:0] h_acc_reg, h_acc_next, h_sum;
  logic [11:0]        dist_acc_reg, dist_acc_next;
  logic [23:0]        h_scaled;

  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      state_reg    <= IDLE;
      vy_reg       <= '0;
      h_acc_reg    <= '0;
      dist_acc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      vy_reg       <= vy_next;
      h_acc_reg    <= h_acc_next;
      dist_acc_reg <= dist_acc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    vy_next       = vy_reg;
    h_acc_next    = h_acc_reg;
    dist_acc_next = dist_acc_reg;
    h_sum         = h_acc_reg + 24'(vy_reg);
    case (state_reg)
      IDLE: begin
        if (i_en) begin
          state_next    = FLY;
          vy_next       = {2'b00, i_v_init};
          h_acc_next    = '0;
          dist_acc_next = '0;
        end
      end
      FLY: begin
        // Abort has priority over a landing tick in the same cycle.
        if (!i_en) begin
          state_next    = IDLE;
          vy_next       = '0;
          h_acc_next    = '0;
          dist_acc_next = '0;
        end else if (i_tick) begin
          vy_next       = vy_reg - 13'(GRAV);
          dist_acc_next = dist_acc_reg + 12'(DX);
          if (h_sum <= 24'sd0) begin
            h_acc_next = '0;
            state_next = DONE;
          end else begin
            h_acc_next = h_sum;
          end
        end
      end
      DONE: begin
        if (!i_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // h_acc is never negative while flying, so the arithmetic shift is a plain scale.
  assign h_scaled = h_acc_reg >>> HSHIFT;
  assign o_height = (state_reg != FLY) ? 9'd0 :
                    (h_scaled > 24'd511) ? 9'd511 : h_scaled[8:0];
  assign o_dist   = (dist_acc_reg > 12'd2047) ? 11'd2047 : dist_acc_reg[10:0];
  assign o_done   = (state_reg == DONE);
  assign o_busy   = (state_reg == FLY);

endmodule

// File: tb/tb_jump_kinematics.sv
// Scoreboard bench for jump_kinematics: closed-form trajectory model pushes
// expected outputs per cycle; a monitor pops and compares on the falling edge.
module tb_jump_kinematics;
  localparam int GRAV   = 1;
  localparam int DX     = 1;
  localparam int HSHIFT = 5;

  logic        clk_machine = 1'b0;
  logic        rst_machine = 1'b0;
  logic        i_tick      = 1'b0;
  logic        i_en        = 1'b0;
  logic [10:0] i_v_init    = '0;
  logic [8:0]  o_height;
  logic [10:0] o_dist;
  logic        o_done;
  logic        o_busy;

  always #5 clk_machine = ~clk_machine;

  jump_kinematics #(.GRAV(GRAV), .DX(DX), .HSHIFT(HSHIFT)) dut (
    .clk_machine(clk_machine),
    .rst_machine(rst_machine),
    .i_tick(i_tick),
    .i_en(i_en),
    .i_v_init(i_v_init),
    .o_height(o_height),
    .o_dist(o_dist),
    .o_done(o_done),
    .o_busy(o_busy)
  );

  typedef struct packed {
    logic [8:0]  h;
    logic [10:0] d;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 flying, 2 landed; height from the closed-form parabola.
  int     m_mode = 0;
  longint m_v = 0, m_n = 0, m_dist = 0;

  function automatic longint traj(input longint v, input longint n);
    return n * v - GRAV * n * (n - 1) / 2;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic t, input logic [10:0] v);
    exp_t   x;
    longint h;
    rst_machine = r;
    i_en        = e;
    i_tick      = t;
    i_v_init    = v;
    @(posedge clk_machine);
    if (r) begin
      m_mode = 0; m_n = 0; m_dist = 0;
    end else if (m_mode == 0) begin
      if (e) begin m_mode = 1; m_v = longint'(v); m_n = 0; m_dist = 0; end
    end else if (m_mode == 1) begin
      if (!e) begin
        m_mode = 0; m_dist = 0;
      end else if (t) begin
        m_n++;
        m_dist = m_n * DX;
        if (traj(m_v, m_n) <= 0) m_mode = 2;
      end
    end else begin
      if (!e) m_mode = 0;
    end
    h      = (m_mode == 1) ? (traj(m_v, m_n) >>> HSHIFT) : 0;
    x.h    = (h > 511) ? 9'd511 : 9'(h);
    x.d    = (m_dist > 2047) ? 11'd2047 : 11'(m_dist);
    x.done = (m_mode == 2);
    x.busy = (m_mode == 1);
    sb.push_back(x);
    #1;
  endtask

  always @(negedge clk_machine) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if ({o_height, o_dist, o_done, o_busy} !== x) begin
        errors++;
        $display("FAIL outputs t=%0t: got h=%0d d=%0d done=%0b busy=%0b, expected h=%0d d=%0d done=%0b busy=%0b",
                 $time, o_height, o_dist, o_done, o_busy, x.h, x.d, x.done, x.busy);
      end
    end
  end

  // One flight: start (with a tick that must be dropped), fly until the model
  // leaves flight, optionally linger with i_en high, then release.
  task automatic run_flight(input logic [10:0] v, input int period, input int abort_tick,
                            input int rst_tick, input int change_tick, input int post);
    int          ticks = 0;
    int          n     = 0;
    logic        t, e, r;
    logic [10:0] vin;
    cyc(1'b0, 1'b1, 1'b1, v);
    while (m_mode == 1 && n < 20000) begin
      t   = (n % period) == (period - 1);
      e   = !(abort_tick > 0 && ticks >= abort_tick);
      r   = (rst_tick > 0 && ticks >= rst_tick);
      vin = (change_tick > 0 && ticks >= change_tick) ? 11'd5 : v;
      cyc(r, e, t, vin);
      if (t) ticks++;
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL flight_budget: got %0d cycles without leaving flight, expected fewer than 20000", n);
    end
    $display("flight v=%0d period=%0d ticks=%0d end_mode=%0d dist=%0d", v, period, ticks, m_mode, m_dist);
    for (int i = 0; i < post; i++) cyc(1'b0, 1'b1, (i % period) == (period - 1), v);
    cyc(1'b0, 1'b0, 1'b0, v);
    cyc(1'b0, 1'b0, 1'b0, v);
  endtask

  initial begin
    int vi;
    cyc(1'b1, 1'b1, 1'b1, 11'd100);
    cyc(1'b1, 1'b1, 1'b1, 11'd100);
    run_flight(11'd127, 4, 0, 0, 0, 4);       // nominal
    run_flight(11'd127, 4, 0, 0, 10, 400);    // v change mid-flight, long hold in DONE
    run_flight(11'd0, 3, 0, 0, 0, 5);         // zero velocity
    run_flight(11'd2047, 1, 0, 0, 0, 3);      // saturation
    run_flight(11'd127, 4, 50, 0, 0, 0);      // abort after tick 50
    run_flight(11'd127, 4, 0, 0, 0, 2);       // fresh flight after abort
    run_flight(11'd127, 1, 0, 100, 0, 0);     // reset mid-flight
    run_flight(11'd3, 1, 6, 0, 0, 0);         // landing tick coincides with abort
    for (int k = 0; k < 8; k++) begin
      vi = int'($urandom_range(0, 300));
      run_flight(11'(vi), int'($urandom_range(1, 3)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * vi + 1)) : 0,
                 0, 0, int'($urandom_range(0, 10)));
    end
    repeat (2) @(negedge clk_machine);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
